// File: rtl/enc_quad_filter_if.sv
// Quadrature front-end bundle: raw lines and strobes in, decoded state out.
// master drives a_in/b_in/preload/preload_val/err_clr; slave returns
// a_filt/b_filt/dir/tick/pos/err/err_cnt.
interface enc_quad_filter_if #(
   parameter int POS_W = 24
);
   logic             a_in;
   logic             b_in;
   logic             preload;
   logic [POS_W-1:0] preload_val;
   logic             err_clr;
   logic             a_filt;
   logic             b_filt;
   logic             dir;
   logic             tick;
   logic [POS_W-1:0] pos;
   logic             err;
   logic [7:0]       err_cnt;

   modport master (
      output a_in, b_in, preload, preload_val, err_clr,
      input  a_filt, b_filt, dir, tick, pos, err, err_cnt
   );

   modport slave (
      input  a_in, b_in, preload, preload_val, err_clr,
      output a_filt, b_filt, dir, tick, pos, err, err_cnt
   );
endinterface

// File: rtl/enc_quad_filter.sv
// Encoder channel front end: 2-flop sync, per-line glitch filter, quadrature
// decoder. Ports: clk, reset (sync, active high), bus (enc_quad_filter_if.slave).
module enc_quad_filter #(
   parameter int FILT_LEN = 4,
   parameter int POS_W    = 24
) (
   input logic         clk,
   input logic         reset,
   enc_quad_filter_if.slave bus
);

   typedef enum logic [1:0] {
      INIT0,
      INIT1,
      RUN
   } state_t;

   localparam logic [3:0] FC_MAX = 4'(FILT_LEN - 1);

   // Bit 1 carries line A, bit 0 carries line B.
   state_t          state_q, state_d;
   logic [1:0]      sync1_q, sync1_d;
   logic [1:0]      sync2_q, sync2_d;
   logic [1:0]      filt_q, filt_d;
   logic [1:0]      prev_q, prev_d;
   logic [1:0][3:0] fc_q, fc_d;
   logic            dir_q, dir_d;
   logic            tick_q, tick_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic            err_q, err_d;
   logic [7:0]      err_cnt_q, err_cnt_d;

   logic [1:0]      chg;
   logic            up;

   assign chg = filt_q ^ prev_q;
   // Moving up, a change on A lands on A!=B and a change on B lands on A==B.
   assign up  = chg[1] ? (filt_q[1] ^ filt_q[0]) : ~(filt_q[1] ^ filt_q[0]);

   always_comb begin
      state_d   = state_q;
      sync1_d   = {bus.a_in, bus.b_in};
      sync2_d   = sync1_q;
      filt_d    = filt_q;
      prev_d    = prev_q;
      fc_d      = fc_q;
      dir_d     = dir_q;
      tick_d    = 1'b0;
      pos_d     = bus.preload ? bus.preload_val : pos_q;
      err_d     = err_q;
      err_cnt_d = err_cnt_q;

      if (bus.err_clr) begin
         err_d     = 1'b0;
         err_cnt_d = 8'd0;
      end

      unique case (state_q)
         INIT0: state_d = INIT1;
         INIT1: begin
            state_d = RUN;
            // sync2 still holds its reset value here; seed from the level
            // it is about to take so RUN starts with no pending change.
            filt_d  = sync1_q;
            prev_d  = sync1_q;
         end
         default: begin
            prev_d = filt_q;
            for (int i = 0; i < 2; i++) begin
               if (sync2_q[i] == filt_q[i]) begin
                  fc_d[i] = 4'd0;
               end else if (fc_q[i] == FC_MAX) begin
                  filt_d[i] = sync2_q[i];
                  fc_d[i]   = 4'd0;
               end else begin
                  fc_d[i] = fc_q[i] + 4'd1;
               end
            end
            unique case (chg)
               2'b00: ;
               2'b11: begin
                  err_d = 1'b1;
                  if (bus.err_clr) begin
                     err_cnt_d = 8'd1;
                  end else if (err_cnt_q != 8'hFF) begin
                     err_cnt_d = err_cnt_q + 8'd1;
                  end
               end
               default: begin
                  tick_d = 1'b1;
                  dir_d  = up;
                  if (!bus.preload) begin
                     pos_d = up ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                  end
               end
            endcase
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= INIT0;
         sync1_q   <= '0;
         sync2_q   <= '0;
         filt_q    <= '0;
         prev_q    <= '0;
         fc_q      <= '0;
         dir_q     <= 1'b0;
         tick_q    <= 1'b0;
         pos_q     <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         filt_q    <= filt_d;
         prev_q    <= prev_d;
         fc_q      <= fc_d;
         dir_q     <= dir_d;
         tick_q    <= tick_d;
         pos_q     <= pos_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.a_filt  = filt_q[1];
   assign bus.b_filt  = filt_q[0];
   assign bus.dir     = dir_q;
   assign bus.tick    = tick_q;
   assign bus.pos     = pos_q;
   assign bus.err     = err_q;
   assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_enc_quad_filter.sv
// Bench for enc_quad_filter: directed scenarios plus a random run checked
// against a cycle-level behavioural model.
module tb_enc_quad_filter;

   localparam int FL = 4;
   localparam int PW = 24;

   logic clk;
   logic reset;

   enc_quad_filter_if #(.POS_W(PW)) bus ();

   enc_quad_filter #(.FILT_LEN(FL), .POS_W(PW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fail;
   int tick_seen;
   logic [1:0] cur;
   logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

   // behavioural model state
   logic [1:0]    rhist [$];
   logic [1:0]    shist [$];
   int            m_since;
   logic [1:0]    mf;
   logic [1:0]    mprev;
   logic          m_dir;
   logic          m_tick;
   logic [PW-1:0] m_pos;
   logic          m_err;
   logic [7:0]    m_cnt;

   function automatic int gidx(logic [1:0] v);
      case (v)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   // Advance the model by one rising edge using the inputs present at it.
   task automatic model_edge();
      logic [1:0] s1, as;
      int d;
      bit all;
      if (reset) begin
         m_since = 0; mf = 0; mprev = 0; m_dir = 0; m_tick = 0;
         m_pos = 0; m_err = 0; m_cnt = 0;
         rhist.delete(); shist.delete();
         return;
      end
      s1 = (rhist.size() >= 1) ? rhist[$] : 2'b00;
      as = (rhist.size() >= 2) ? rhist[$-1] : 2'b00;
      rhist.push_back({bus.a_in, bus.b_in});
      if (rhist.size() > 4) void'(rhist.pop_front());
      m_tick = 0;
      if (bus.preload) m_pos = bus.preload_val;
      if (bus.err_clr) begin m_err = 0; m_cnt = 0; end
      if (m_since == 0) begin
         m_since = 1;
      end else if (m_since == 1) begin
         mf = s1; mprev = s1; m_since = 2; shist.delete();
      end else begin
         d = (gidx(mf) - gidx(mprev) + 4) % 4;
         mprev = mf;
         shist.push_back(as);
         if (shist.size() > FL) void'(shist.pop_front());
         if (shist.size() == FL) begin
            for (int i = 0; i < 2; i++) begin
               all = 1;
               foreach (shist[j]) if (shist[j][i] == mf[i]) all = 0;
               if (all) mf[i] = ~mf[i];
            end
         end
         if (d == 1 || d == 3) begin
            m_tick = 1;
            m_dir = (d == 1);
            if (!bus.preload) m_pos = (d == 1) ? m_pos + 1 : m_pos - 1;
         end else if (d == 2) begin
            m_err = 1;
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 1;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      if (bus.tick === 1'b1) tick_seen++;
   endtask

   task automatic set_lines(input logic [1:0] v);
      bus.a_in = v[1];
      bus.b_in = v[0];
      cur = v;
   endtask

   task automatic test_reset();
      logic [36:0] got;
      reset = 1;
      set_lines(2'b11);
      repeat (3) step();
      got = {bus.a_filt, bus.b_filt, bus.dir, bus.tick, bus.err,
             bus.err_cnt, bus.pos};
      n_checks++;
      if (got !== 37'd0) begin
         n_fail++; $display("FAIL reset_outs got=%h exp=0", got);
      end
      reset = 0;
      step(); step();
      n_checks++;
      if ({bus.a_filt, bus.b_filt} !== 2'b11) begin
         n_fail++; $display("FAIL startup_filt got=%b exp=11",
                            {bus.a_filt, bus.b_filt});
      end
      n_checks++;
      if (bus.err !== 1'b0 || bus.pos !== 24'd0) begin
         n_fail++; $display("FAIL startup_state err=%b pos=%h exp 0/0",
                            bus.err, bus.pos);
      end
      tick_seen = 0;
      repeat (12) step();
      n_checks++;
      if (tick_seen !== 0) begin
         n_fail++; $display("FAIL startup_tick got=%0d exp=0", tick_seen);
      end
   endtask

   task automatic run_edges(input int dirn, output int bad);
      bad = 0;
      for (int e = 0; e < 16; e++) begin
         set_lines(seq[(gidx(cur) + (dirn > 0 ? 1 : 3)) % 4]);
         for (int c = 1; c <= 10; c++) begin
            step();
            if (bus.tick !== (c == 7)) bad++;
         end
      end
   endtask

   task automatic test_forward();
      int bad;
      tick_seen = 0;
      run_edges(1, bad);
      n_checks++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL fwd_latency bad=%0d exp=0", bad);
      end
      n_checks++;
      if (tick_seen !== 16) begin
         n_fail++; $display("FAIL fwd_ticks got=%0d exp=16", tick_seen);
      end
      n_checks++;
      if (bus.pos !== 24'd16 || bus.dir !== 1'b1) begin
         n_fail++; $display("FAIL fwd_pos pos=%h dir=%b exp 10/1",
                            bus.pos, bus.dir);
      end
      run_edges(-1, bad);
      n_checks++;
      if (bad !== 0) begin
         n_fail++; $display("FAIL rev_latency bad=%0d exp=0", bad);
      end
      n_checks++;
      if (bus.pos !== 24'd0 || bus.dir !== 1'b0) begin
         n_fail++; $display("FAIL rev_pos pos=%h dir=%b exp 0/0",
                            bus.pos, bus.dir);
      end
   endtask

   task automatic test_glitch();
      logic [1:0] base;
      logic [PW-1:0] p0;
      int bad;
      base = cur;
      p0 = bus.pos;
      tick_seen = 0;
      bad = 0;
      set_lines({~base[1], base[0]});
      repeat (3) begin step(); if (bus.a_filt !== base[1]) bad++; end
      set_lines(base);
      repeat (12) begin step(); if (bus.a_filt !== base[1]) bad++; end
      n_checks++;
      if (bad !== 0 || tick_seen !== 0 || bus.pos !== p0) begin
         n_fail++; $display("FAIL glitch3 bad=%0d ticks=%0d pos=%h exp 0/0/%h",
                            bad, tick_seen, bus.pos, p0);
      end
      set_lines({~base[1], base[0]});
      repeat (4) step();
      set_lines(base);
      repeat (14) step();
      n_checks++;
      if (tick_seen !== 2 || bus.pos !== p0) begin
         n_fail++; $display("FAIL glitch4 ticks=%0d pos=%h exp 2/%h",
                            tick_seen, bus.pos, p0);
      end
   endtask

   task automatic test_illegal();
      logic [PW-1:0] p0;
      logic d0;
      p0 = bus.pos;
      d0 = bus.dir;
      tick_seen = 0;
      set_lines(~cur);
      repeat (10) step();
      n_checks++;
      if (bus.err !== 1'b1 || bus.err_cnt !== 8'd1) begin
         n_fail++; $display("FAIL illegal_one err=%b cnt=%0d exp 1/1",
                            bus.err, bus.err_cnt);
      end
      n_checks++;
      if (bus.pos !== p0 || bus.dir !== d0 || tick_seen !== 0) begin
         n_fail++; $display("FAIL illegal_hold pos=%h dir=%b ticks=%0d",
                            bus.pos, bus.dir, tick_seen);
      end
      repeat (299) begin
         set_lines(~cur);
         repeat (8) step();
      end
      n_checks++;
      if (bus.err_cnt !== 8'd255) begin
         n_fail++; $display("FAIL illegal_sat got=%0d exp=255", bus.err_cnt);
      end
      set_lines(~cur);
      repeat (6) step();
      bus.err_clr = 1;
      step();
      bus.err_clr = 0;
      n_checks++;
      if (bus.err !== 1'b1 || bus.err_cnt !== 8'd1) begin
         n_fail++; $display("FAIL clr_with_illegal err=%b cnt=%0d exp 1/1",
                            bus.err, bus.err_cnt);
      end
      repeat (3) step();
      bus.err_clr = 1;
      step();
      bus.err_clr = 0;
      n_checks++;
      if (bus.err !== 1'b0 || bus.err_cnt !== 8'd0) begin
         n_fail++; $display("FAIL err_clr err=%b cnt=%0d exp 0/0",
                            bus.err, bus.err_cnt);
      end
   endtask

   task automatic test_wrap_preload();
      bus.preload = 1;
      bus.preload_val = 24'd0;
      step();
      bus.preload = 0;
      set_lines(seq[(gidx(cur) + 3) % 4]);
      repeat (10) step();
      n_checks++;
      if (bus.pos !== 24'hFFFFFF || bus.dir !== 1'b0) begin
         n_fail++; $display("FAIL wrap pos=%h dir=%b exp ffffff/0",
                            bus.pos, bus.dir);
      end
      set_lines(seq[(gidx(cur) + 1) % 4]);
      repeat (6) step();
      bus.preload = 1;
      bus.preload_val = 24'h123456;
      step();
      bus.preload = 0;
      n_checks++;
      if (bus.pos !== 24'h123456 || bus.tick !== 1'b1 || bus.dir !== 1'b1) begin
         n_fail++; $display("FAIL preload_edge pos=%h tick=%b dir=%b exp 123456/1/1",
                            bus.pos, bus.tick, bus.dir);
      end
      repeat (4) step();
   endtask

   task automatic test_reset_mid();
      logic [36:0] got;
      bus.preload = 1;
      bus.preload_val = 24'h000100;
      step();
      bus.preload = 0;
      n_checks++;
      if (bus.pos !== 24'h000100) begin
         n_fail++; $display("FAIL mid_preload pos=%h exp=000100", bus.pos);
      end
      reset = 1;
      step();
      reset = 0;
      got = {bus.a_filt, bus.b_filt, bus.dir, bus.tick, bus.err,
             bus.err_cnt, bus.pos};
      n_checks++;
      if (got !== 37'd0) begin
         n_fail++; $display("FAIL mid_reset got=%h exp=0", got);
      end
      step(); step();
      n_checks++;
      if ({bus.a_filt, bus.b_filt} !== cur) begin
         n_fail++; $display("FAIL mid_init got=%b exp=%b",
                            {bus.a_filt, bus.b_filt}, cur);
      end
      tick_seen = 0;
      repeat (20) step();
      n_checks++;
      if (tick_seen !== 0 || bus.err !== 1'b0 || bus.pos !== 24'd0) begin
         n_fail++; $display("FAIL mid_quiet ticks=%0d err=%b pos=%h exp 0/0/0",
                            tick_seen, bus.err, bus.pos);
      end
   endtask

   task automatic test_random();
      logic [36:0] got, exp;
      logic [1:0] v;
      int r, hold;
      for (int n = 0; n < 120; n++) begin
         r = $urandom_range(0, 9);
         if (r < 4)      v = seq[(gidx(cur) + 1) % 4];
         else if (r < 7) v = seq[(gidx(cur) + 3) % 4];
         else if (r < 8) v = ~cur;
         else            v = cur ^ 2'b10;
         set_lines(v);
         bus.preload     = ($urandom_range(0, 15) == 0);
         bus.preload_val = 24'($urandom);
         bus.err_clr     = ($urandom_range(0, 15) == 0);
         hold = $urandom_range(1, 9);
         for (int c = 0; c < hold; c++) begin
            step();
            bus.preload = 0;
            bus.err_clr = 0;
            got = {bus.a_filt, bus.b_filt, bus.dir, bus.tick, bus.err,
                   bus.err_cnt, bus.pos};
            exp = {mf, m_dir, m_tick, m_err, m_cnt, m_pos};
            n_checks++;
            if (got !== exp) begin
               n_fail++; $display("FAIL random n=%0d got=%h exp=%h", n, got, exp);
            end
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      tick_seen = 0;
      reset = 1;
      bus.a_in = 1;
      bus.b_in = 1;
      bus.preload = 0;
      bus.preload_val = '0;
      bus.err_clr = 0;
      cur = 2'b11;
      test_reset();
      test_forward();
      test_glitch();
      test_illegal();
      test_wrap_preload();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
